// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
//   Sequential binary-to-BCD converter using shift-add-3 (double dabble).
//   It processes one input bit per clock. It converts the up/down counter's
//   count into packed BCD digits for the display stage. The result register
//   changes only on a completion edge, so the display path always latches a
//   complete and coherent set of digits.
//
// Parameters
//   WIDTH  : bit width of the binary input (must be >= 2).
//   DIGITS : number of BCD digits. The design requires 10^DIGITS > 2^WIDTH - 1.
//
// Ports
//   clk   in   1          clock; all state updates occur on the rising edge
//   rst   in   1          asynchronous, active-high reset
//   start in   1          conversion request; sampled only in IDLE
//   bin   in   WIDTH      binary value; sampled only on the accepting edge
//   busy  out  1          high while a conversion is in progress
//   done  out  1          one-cycle pulse when bcd has just been updated
//   bcd   out  4*DIGITS   packed BCD result; digit k is at [4k+3:4k], k=0 is units
// ---------------------------------------------------------------------------
module bin2bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);

    // The digit count must be able to hold the largest binary input.
    generate
        if ((10 ** DIGITS) <= ((2 ** WIDTH) - 1)) begin : g_digits_check
            $error("bin2bcd_seq: DIGITS=%0d too small for WIDTH=%0d", DIGITS, WIDTH);
        end
    endgenerate

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_shift;
    logic [BCD_W-1:0]   r_scratch;
    logic [CNT_W-1:0]   r_count;
    logic [BCD_W-1:0]   r_bcd;
    logic               r_done;

    logic [BCD_W-1:0]   w_adj;       // scratch after the parallel add-3 step
    logic [BCD_W-1:0]   w_shifted;   // scratch after the add-3 step and the shift
    logic               w_last;      // current edge performs the final shift

    // ---------------- FSM state register ----------------
    // NOTE: sequential state uses non-blocking (<=) assignments. This way every
    // flop samples the values from before the edge, and process order does not matter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM next-state logic ----------------
    // NOTE: the default is assigned first so that every path drives the signal.
    // Without it, synthesis would infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_count == CNT_W'(1)) begin
                    w_last       = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // ---------------- add-3 correction ----------------
    // Every digit is tested on its value before the add, in parallel. A digit
    // of 5 or more would reach 10 or more after doubling, so adding 3 now makes
    // the shift carry correctly into the next digit.
    always_comb begin
        w_adj = r_scratch;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_scratch[4*k +: 4] >= 4'd5) begin
                w_adj[4*k +: 4] = r_scratch[4*k +: 4] + 4'd3;
            end
        end
    end

    // The MSB of the binary shift register enters bit 0 of the scratch register.
    assign w_shifted = {w_adj[BCD_W-2:0], r_shift[WIDTH-1]};

    // ---------------- datapath ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift   <= '0;
            r_scratch <= '0;
            r_count   <= '0;
            r_bcd     <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_shift   <= bin;
                        r_scratch <= '0;
                        r_count   <= CNT_W'(WIDTH);
                    end
                end
                S_SHIFT: begin
                    r_scratch <= w_shifted;
                    r_shift   <= {r_shift[WIDTH-2:0], 1'b0};
                    r_count   <= r_count - CNT_W'(1);
                    if (w_last) begin
                        r_bcd  <= w_shifted;
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // busy is decoded directly from the state flop. It is glitch-free because
    // it depends on a single register bit.
    assign busy = (r_state == S_SHIFT);
    assign done = r_done;
    assign bcd  = r_bcd;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// tb_bin2bcd_seq
//   Directed testbench for bin2bcd_seq with WIDTH=8 and DIGITS=3.
//   Inputs are driven on the falling edge, and outputs are sampled on the
//   falling edge. Each edge index used below refers to a rising edge.
// ---------------------------------------------------------------------------
module tb_bin2bcd_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  bin;
    logic        busy;
    logic        done;
    logic [11:0] bcd;

    int n_tests = 0;
    int n_fail  = 0;

    bin2bcd_seq #(
        .WIDTH  (8),
        .DIGITS (3)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model for the exhaustive sweep. It uses decimal division,
    // which is independent of the shift-add-3 method in the design.
    function automatic logic [11:0] dec2bcd(input int v);
        dec2bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // This task runs one conversion. Start is presented for one edge (E0).
    // Bin is then scrambled to show that only the accepting edge samples it.
    task automatic run_conv(input string tag, input logic [7:0] v,
                            input logic [11:0] exp, input bit chk_timing);
        @(negedge clk);
        start = 1'b1;
        bin   = v;
        @(negedge clk);                      // after E0
        start = 1'b0;
        bin   = ~v;
        if (chk_timing) begin
            check({tag, " busy@E0"}, 32'(busy), 32'd1);
            check({tag, " done@E0"}, 32'(done), 32'd0);
        end
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);                  // after E_i
            if (chk_timing && i < 8) begin
                check($sformatf("%s busy@E%0d", tag, i), 32'(busy), 32'd1);
                check($sformatf("%s done@E%0d", tag, i), 32'(done), 32'd0);
            end
        end
        check({tag, " done@E8"}, 32'(done), 32'd1);
        check({tag, " busy@E8"}, 32'(busy), 32'd0);
        check({tag, " bcd"},     32'(bcd),  32'(exp));
        @(negedge clk);
        if (chk_timing) begin
            check({tag, " done@E9"}, 32'(done), 32'd0);
            check({tag, " bcd hold"}, 32'(bcd), 32'(exp));
        end
    endtask

    initial begin
        int done_seen;
        logic [7:0] cnt;

        rst   = 1'b1;
        start = 1'b0;
        bin   = 8'd0;

        // ---------------- reset state, then idle ----------------
        #3;
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst bcd",  32'(bcd),  32'h000);
        #20;
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
            if (busy === 1'b1) done_seen++;
        end
        check("idle no done/busy", 32'(done_seen), 32'd0);
        check("idle bcd", 32'(bcd), 32'h000);

        // ---------------- basic values, full timing checks ----------------
        run_conv("v0",   8'd0,   12'h000, 1'b1);
        run_conv("v9",   8'd9,   12'h009, 1'b1);
        run_conv("v10",  8'd10,  12'h010, 1'b1);
        run_conv("v99",  8'd99,  12'h099, 1'b1);
        run_conv("v100", 8'd100, 12'h100, 1'b1);
        run_conv("v128", 8'd128, 12'h128, 1'b1);
        run_conv("v255", 8'd255, 12'h255, 1'b1);

        // ---------------- start while busy is ignored ----------------
        @(negedge clk);
        start = 1'b1;
        bin   = 8'd37;
        @(negedge clk);                      // after E0
        start = 1'b0;
        bin   = 8'd0;
        @(negedge clk);                      // after E1
        @(negedge clk);                      // after E2
        start = 1'b1;
        bin   = 8'd200;                      // sampled at E3, must be ignored
        @(negedge clk);                      // after E3
        start = 1'b0;
        for (int i = 4; i <= 8; i++) @(negedge clk);
        check("busy-start done@E8", 32'(done), 32'd1);
        check("busy-start bcd",     32'(bcd),  32'h037);
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        check("busy-start no 2nd conv", 32'(done_seen), 32'd0);
        check("busy-start bcd kept",    32'(bcd),       32'h037);

        // ---------------- back-to-back, start held high ----------------
        // bin follows a free-running count starting at 250. The accepting
        // edges are c = 0, 9, 18, ... and the matching done is seen after edge c+8.
        cnt = 8'd250;
        @(negedge clk);
        start = 1'b1;
        bin   = cnt;
        for (int c = 0; c <= 44; c++) begin
            @(negedge clk);                  // after edge c
            cnt = cnt + 8'd1;
            bin = cnt;
            if (c == 44) start = 1'b0;
            check($sformatf("b2b done@%0d", c), 32'(done), 32'((c % 9) == 8));
            if ((c % 9) == 8) begin
                check($sformatf("b2b bcd@%0d", c), 32'(bcd),
                      32'(dec2bcd((250 + c - 8) % 256)));
            end
        end
        @(negedge clk);
        check("b2b stops", 32'(busy), 32'd0);

        // ---------------- reset mid-conversion ----------------
        @(negedge clk);
        start = 1'b1;
        bin   = 8'd255;
        @(posedge clk);                      // E0
        #1 start = 1'b0;
        repeat (4) @(posedge clk);           // E4
        #1 rst = 1'b1;
        #1;
        check("mid-rst busy", 32'(busy), 32'd0);
        check("mid-rst bcd",  32'(bcd),  32'h000);
        check("mid-rst done", 32'(done), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        check("mid-rst no done", 32'(done_seen), 32'd0);
        check("mid-rst bcd held 0", 32'(bcd), 32'h000);
        run_conv("after-rst v42", 8'd42, 12'h042, 1'b1);

        // ---------------- exhaustive sweep ----------------
        for (int v = 0; v < 256; v++) begin
            run_conv($sformatf("sweep %0d", v), 8'(v), dec2bcd(v), 1'b0);
            for (int k = 0; k < 3; k++) begin
                check($sformatf("sweep %0d digit%0d<=9", v, k),
                      32'(((bcd >> (4 * k)) & 12'hF) <= 12'd9), 32'd1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
